// File: rtl/input_loader.sv
// input_loader: unpacks the weight-then-pixel byte stream into binary kernels and image
module input_loader #(
  parameter int N_KERNELS = 8,
  parameter int IMG_DIM   = 28,
  parameter int W_BYTES   = 9,
  parameter int P_BYTES   = 98
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           state,
  input  logic [7:0]           data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic [IMG_DIM-1:0]   pixels [IMG_DIM-1:0],
  output logic [2:0][2:0]      weights [N_KERNELS-1:0],
  output logic                 done
);
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [1:0] L_IDLE    = 2'd0;
  localparam logic [1:0] L_WEIGHTS = 2'd1;
  localparam logic [1:0] L_PIXELS  = 2'd2;
  localparam logic [1:0] L_DONE    = 2'd3;
  logic [1:0]                   st_q, st_d;
  logic [6:0]                   cnt_q, cnt_d;
  logic [N_KERNELS*9-1:0]       w_q;
  logic [IMG_DIM*IMG_DIM-1:0]   p_q;
  logic [9:0]                   base;
  logic                         acc;
  assign data_ready = (st_q == L_WEIGHTS || st_q == L_PIXELS) && state == S_LOAD;
  assign acc        = data_valid && data_ready;
  assign done       = st_q == L_DONE;
  assign base       = {cnt_q, 3'b000};
  always_comb begin
    st_d  = st_q;
    cnt_d = acc ? cnt_q + 7'd1 : cnt_q;
    if (st_q == L_IDLE && state == S_LOAD) st_d = L_WEIGHTS;
    if (acc && st_q == L_WEIGHTS && cnt_q == 7'(W_BYTES - 1)) begin
      st_d  = L_PIXELS;
      cnt_d = '0;
    end
    if (acc && st_q == L_PIXELS && cnt_q == 7'(P_BYTES - 1)) st_d = L_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= L_IDLE;
      cnt_q <= '0;
      w_q   <= '0;
      p_q   <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      if (acc && st_q == L_WEIGHTS) w_q[base[6:0] +: 8] <= data_in;
      if (acc && st_q == L_PIXELS) p_q[base +: 8] <= data_in;
    end
  end
  // Stream bit j lands at flat index j, so row/kernel slices fall out directly.
  for (genvar r = 0; r < IMG_DIM; r++) begin : g_pix
    assign pixels[r] = p_q[r*IMG_DIM +: IMG_DIM];
  end
  for (genvar n = 0; n < N_KERNELS; n++) begin : g_wgt
    assign weights[n] = w_q[n*9 +: 9];
  end
endmodule

// File: tb/tb_input_loader.sv
// tb_input_loader: randomized scoreboard bench for input_loader
module tb_input_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  state = 3'd1;
  logic [7:0]  data_in = 8'h00;
  logic        data_valid = 1'b0;
  logic        data_ready, done;
  logic [27:0] pixels [27:0];
  logic [2:0][2:0] weights [7:0];

  always #5 clk = ~clk;

  input_loader dut (
    .clk(clk), .rst(rst), .state(state), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .pixels(pixels), .weights(weights), .done(done)
  );

  typedef struct packed {
    logic [27:0][27:0]     p;
    logic [7:0][2:0][2:0]  w;
    logic                  d;
  } exp_t;

  exp_t q[$];
  logic [27:0][27:0]    mp;
  logic [7:0][2:0][2:0] mw;
  int mk = 0;
  int n_chk = 0, n_pass = 0;

  function automatic logic [783:0] dut_p();
    logic [27:0][27:0] v;
    for (int r = 0; r < 28; r++) v[r] = pixels[r];
    return v;
  endfunction

  function automatic logic [71:0] dut_w();
    logic [7:0][2:0][2:0] v;
    for (int n = 0; n < 8; n++) v[n] = weights[n];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [783:0] a, input logic [783:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask

  task automatic chk1(input string nm, input logic a, input logic e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, a, e);
  endtask

  task automatic check_model(input string nm);
    chk({nm, " pixels"}, dut_p(), mp);
    chk({nm, " weights"}, 784'(dut_w()), 784'(mw));
  endtask

  // Reference: stream bit j of a section goes to pixel (j/28, j%28) or kernel j/9, cell j%9.
  task automatic model_apply(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      int j;
      if (mk < 9) begin
        j = 8 * mk + i;
        mw[j / 9][(j % 9) / 3][(j % 9) % 3] = b[i];
      end else begin
        j = 8 * (mk - 9) + i;
        mp[j / 28][j % 28] = b[i];
      end
    end
    mk++;
    q.push_back('{p: mp, w: mw, d: 1'(mk == 107)});
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    logic r;
    t = 0;
    @(negedge clk);
    data_valid = 1'b1;
    data_in    = b;
    forever begin
      #2 r = data_ready && !rst;
      @(posedge clk);
      if (r) break;
      if (++t > 40) begin
        n_chk++;
        $display("FAIL send_byte: byte %0d never accepted", mk);
        break;
      end
      @(negedge clk);
    end
    if (r) model_apply(b);
  endtask

  task automatic idle();
    @(negedge clk);
    data_valid = 1'b0;
    data_in    = 8'($urandom);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst        = 1'b1;
    data_valid = 1'b1;
    data_in    = 8'hFF;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      chk("reset pixels", dut_p(), '0);
      chk("reset weights", 784'(dut_w()), '0);
      chk1("reset done", done, 1'b0);
      chk1("reset data_ready", data_ready, 1'b0);
    end
    @(negedge clk);
    rst        = 1'b0;
    data_valid = 1'b0;
    mp = '0;
    mw = '0;
    mk = 0;
  endtask

  // Monitor: every accepting edge must be matched by a scoreboard entry.
  initial begin
    logic a;
    exp_t e;
    forever begin
      @(negedge clk);
      #2 a = data_valid && data_ready && !rst;
      @(posedge clk);
      #1;
      if (a) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL monitor: accept with empty scoreboard");
        end else begin
          e = q.pop_front();
          chk("mon pixels", dut_p(), e.p);
          chk("mon weights", 784'(dut_w()), 784'(e.w));
          chk1("mon done", done, e.d);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    mp = '0;
    mw = '0;
    do_reset(2);
    for (int k = 0; k < 107; k++)
      send_byte(k == 0 ? 8'h01 : k == 1 ? 8'h02 : k == 9 ? 8'h01 : k == 12 ? 8'hF0 : 8'h00);
    @(negedge clk);
    data_valid = 1'b0;
    #1;
    chk1("w[0][0][0]", weights[0][0][0], 1'b1);
    chk1("w[1][0][0]", weights[1][0][0], 1'b1);
    chk1("p[0][0]", pixels[0][0], 1'b1);
    chk("p[1][3:0]", 784'(pixels[1][3:0]), 784'(4'hF));
    chk("p[0][27:24]", 784'(pixels[0][27:24]), '0);
    chk1("done after load", done, 1'b1);
    repeat (20) begin
      @(negedge clk);
      data_valid = 1'b1;
      data_in    = 8'hAA;
      #1;
      chk1("post-done ready", data_ready, 1'b0);
      check_model("post-done");
    end
    repeat (3) begin
      @(negedge clk);
      state      = 3'd2;
      data_valid = 1'b0;
      #1;
      chk1("done sticky", done, 1'b1);
    end
    state = 3'd1;

    do_reset(1);
    for (int k = 0; k < 107; k++) begin
      while ($urandom_range(0, 9) >= 3) idle();
      send_byte(8'hFF);
    end
    @(negedge clk);
    data_valid = 1'b0;
    #1;
    chk("ones pixels", dut_p(), {784{1'b1}});
    chk("ones weights", 784'(dut_w()), 784'({72{1'b1}}));

    do_reset(1);
    for (int k = 0; k < 50; k++) send_byte(8'($urandom));
    repeat (10) begin
      @(negedge clk);
      state      = 3'd3;
      data_valid = 1'($urandom_range(0, 1));
      data_in    = 8'($urandom);
      #1;
      chk1("pause ready", data_ready, 1'b0);
      check_model("pause");
    end
    @(negedge clk);
    state      = 3'd1;
    data_valid = 1'b0;
    b = 8'($urandom);
    send_byte(b);
    @(negedge clk);
    data_valid = 1'b0;
    #1;
    chk("resume p[11][27:20]", 784'(pixels[11][27:20]), 784'(b));
    for (int k = 51; k < 107; k++) send_byte(8'($urandom));
    @(negedge clk);
    data_valid = 1'b0;

    do_reset(1);
    for (int k = 0; k < 60; k++) send_byte(8'($urandom));
    do_reset(1);
    for (int k = 0; k < 107; k++) send_byte(8'($urandom));
    @(negedge clk);
    data_valid = 1'b0;
    #1;
    chk1("reload done", done, 1'b1);
    check_model("reload");
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 784'(q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/input_loader.md
Name: input_loader

Overview:
- Sits upstream of the first convolution layer.
- During the top-level s_LOAD state it accepts a byte stream from the chip inputs: 9 weight bytes first, then 98 pixel bytes.
- It unpacks the stream into the 28x28 binary image and the eight 3x3 binary kernels that the first layer reads in parallel.
- It raises a sticky done flag so the top FSM can advance to s_LAYER_1.

Parameters:
- N_KERNELS, 8, number of 3x3 binary kernels loaded.
- IMG_DIM, 28, image side length in pixels.
- W_BYTES, 9, weight bytes; equals ceil(N_KERNELS*9/8).
- P_BYTES, 98, pixel bytes; equals IMG_DIM*IMG_DIM/8.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- state  in  3  top-level state_t (s_IDLE=0, s_LOAD=1, s_LAYER_1=2, s_LAYER_2=3, s_LAYER_3=4).
- data_in  in  8  stream byte.
- data_valid  in  1  data_in holds a valid byte this cycle.
- data_ready  out  1  loader can accept a byte this cycle.
- pixels  out  28x28  unpacked [27:0] of packed [27:0]; pixels[r][c] is row r, column c.
- weights  out  8x3x3  [2:0][2:0] per kernel, unpacked [7:0]; weights[n][r][c].
- done  out  1  all 107 bytes received; sticky.

Behaviour:
- Reset (rst=1 at posedge): pixels, weights, done, data_ready = 0; byte counter = 0; FSM to L_IDLE. Reset mid-load discards all partial data.
- FSM states:
  - L_IDLE -> L_WEIGHTS when state==s_LOAD and done==0.
  - L_WEIGHTS -> L_PIXELS on acceptance of weight byte 8.
  - L_PIXELS -> L_DONE on acceptance of pixel byte 97.
  - L_DONE is held until rst.
- data_ready = 1 only when the FSM is in L_WEIGHTS or L_PIXELS and state==s_LOAD. It is combinational from the registered FSM state and the state input.
- A byte is accepted at a posedge where data_valid && data_ready. Bytes with data_valid=0 or data_ready=0 are ignored, with no side effects.
- Stream bit index j = 8*k + i, where k is the byte number within its section (weights or pixels) and i is the bit position within data_in. Bit 0 (LSB) comes first.
- Weight mapping: for j in 0..71, n=j/9, m=j%9, weights[n][m/3][m%3] = bit j.
- Pixel mapping: for j in 0..783, pixels[j/28][j%28] = bit j. Bytes 3, 10, 17, ... straddle two rows: low nibble ends row r, high nibble starts row r+1.
- Write latency: bits of an accepted byte are visible on pixels/weights from the cycle after the accepting edge. Bits not yet written keep their prior value (0 after reset).
- done: set at the edge that accepts pixel byte 97, so it is visible the next cycle. It stays 1 until rst, including after state leaves s_LOAD. From that cycle on, data_ready=0.
- Pause: if state leaves s_LOAD mid-load, data_ready drops in the same cycle. The counter, FSM and data hold, and loading resumes at the same byte when state returns to s_LOAD.
- Counter width is 7 bits; it clears to 0 on the WEIGHTS->PIXELS transition and never wraps.
- Outputs must be stable while state != s_LOAD. The loader never modifies pixels/weights outside s_LOAD.

Test Plan:
- Reset check: hold rst 2 cycles with state=s_LOAD and data_valid=1 -> pixels==0, weights==0, done=0, data_ready=0 during reset.
- Full load, mapping check:
  - Drive weight byte 0=0x01 and byte 1=0x02, other weight bytes 0x00 -> weights[0][0][0]=1, weights[1][0][0]=1 (bit 9), all other weight bits 0.
  - Drive pixel byte 0=0x01 and byte 3=0xF0, others 0x00 -> pixels[0][0]=1, pixels[1][3:0]=4'hF, pixels[0][27:24]=0.
  - done=1 exactly one cycle after the 107th accepted byte.
- Backpressure/gaps: random data_valid duty of 30% with an all-ones stream -> every pixel and weight bit is 1 after 107 accepts, and done does not assert early.
- Pause: after 50 accepted bytes, switch state to s_LAYER_2 for 10 cycles while toggling data_valid -> data_ready=0 and outputs unchanged. Return to s_LOAD; the next byte is written as byte 50 (pixel byte 41 -> pixels[11][20..27]).
- Post-done: keep data_valid=1 with 0xAA after done -> data_ready=0 and pixels/weights unchanged over 20 cycles.
- Reset mid-load: assert rst after 60 bytes -> all outputs 0. A fresh 107-byte load completes with done=1 and the new pattern only.
